// File: rtl/conv_addr_seq.sv
// Address sequencer for a 3x3xC convolution window sweep over a W x H x C feature map.
// Streams one input-memory read address per accepted handshake, with window/sweep markers.
module conv_addr_seq #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DIM_W-1:0]  cfg_chans,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr,
    output logic              win_first,
    output logic              win_last,
    output logic              conv_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;

    // Latched configuration
    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_c;
    logic [ADDR_W-1:0] r_plane;

    // Loop counters, outermost first
    logic [DIM_W-1:0]  r_row;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_k;
    logic [1:0]        r_ky;
    logic [1:0]        r_kx;

    // Running base addresses so each step needs only an add, never a multiply
    logic [ADDR_W-1:0] r_rowstart;
    logic [ADDR_W-1:0] r_win_base;
    logic [ADDR_W-1:0] r_chan_base;
    logic [ADDR_W-1:0] r_line_base;

    logic [DIM_W-1:0]  w_row;
    logic [DIM_W-1:0]  w_col;
    logic [DIM_W-1:0]  w_k;
    logic [1:0]        w_ky;
    logic [1:0]        w_kx;
    logic [ADDR_W-1:0] w_rowstart;
    logic [ADDR_W-1:0] w_win_base;
    logic [ADDR_W-1:0] w_chan_base;
    logic [ADDR_W-1:0] w_line_base;
    logic [ADDR_W-1:0] w_addr;
    logic              w_end;
    logic              w_first;
    logic              w_wlast;
    logic              w_clast;
    logic              w_cfg_ok;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_width_a;

    assign w_width_a = ADDR_W'(r_w);
    assign w_xfer    = addr_valid & addr_ready;
    assign w_cfg_ok  = (cfg_width >= DIM_W'(3)) && (cfg_height >= DIM_W'(3))
                       && (cfg_chans != DIM_W'(0));

    // Successor element of the nested r/c/k/ky/kx walk
    always_comb begin
        w_row       = r_row;
        w_col       = r_col;
        w_k         = r_k;
        w_ky        = r_ky;
        w_kx        = r_kx + 2'd1;
        w_rowstart  = r_rowstart;
        w_win_base  = r_win_base;
        w_chan_base = r_chan_base;
        w_line_base = r_line_base;
        w_addr      = addr + ADDR_W'(1);
        w_end       = 1'b0;
        if (r_kx == 2'd2) begin
            w_kx = 2'd0;
            if (r_ky != 2'd2) begin
                w_ky        = r_ky + 2'd1;
                w_line_base = r_line_base + w_width_a;
                w_addr      = w_line_base;
            end else begin
                w_ky = 2'd0;
                if (r_k != r_c - DIM_W'(1)) begin
                    w_k         = r_k + DIM_W'(1);
                    w_chan_base = r_chan_base + r_plane;
                    w_line_base = w_chan_base;
                    w_addr      = w_chan_base;
                end else begin
                    w_k = DIM_W'(0);
                    if (r_col != r_w - DIM_W'(3)) begin
                        w_col       = r_col + DIM_W'(1);
                        w_win_base  = r_win_base + ADDR_W'(1);
                        w_chan_base = w_win_base;
                        w_line_base = w_win_base;
                        w_addr      = w_win_base;
                    end else begin
                        w_col = DIM_W'(0);
                        if (r_row != r_h - DIM_W'(3)) begin
                            w_row       = r_row + DIM_W'(1);
                            w_rowstart  = r_rowstart + w_width_a;
                            w_win_base  = w_rowstart;
                            w_chan_base = w_rowstart;
                            w_line_base = w_rowstart;
                            w_addr      = w_rowstart;
                        end else begin
                            w_end = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign w_first = (w_k == DIM_W'(0)) && (w_ky == 2'd0) && (w_kx == 2'd0);
    assign w_wlast = (w_k == r_c - DIM_W'(1)) && (w_ky == 2'd2) && (w_kx == 2'd2);
    assign w_clast = (w_row == r_h - DIM_W'(3)) && (w_col == r_w - DIM_W'(3));

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_w         <= '0;
            r_h         <= '0;
            r_c         <= '0;
            r_plane     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_ky        <= '0;
            r_kx        <= '0;
            r_rowstart  <= '0;
            r_win_base  <= '0;
            r_chan_base <= '0;
            r_line_base <= '0;
            addr_valid  <= 1'b0;
            addr        <= '0;
            win_first   <= 1'b0;
            win_last    <= 1'b0;
            conv_last   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!abort && start) begin
                        r_w         <= cfg_width;
                        r_h         <= cfg_height;
                        r_c         <= cfg_chans;
                        r_plane     <= ADDR_W'(cfg_width) * ADDR_W'(cfg_height);
                        r_row       <= '0;
                        r_col       <= '0;
                        r_k         <= '0;
                        r_ky        <= '0;
                        r_kx        <= '0;
                        r_rowstart  <= '0;
                        r_win_base  <= '0;
                        r_chan_base <= '0;
                        r_line_base <= '0;
                        addr        <= '0;
                        busy        <= 1'b1;
                        err         <= !w_cfg_ok;
                        if (w_cfg_ok) begin
                            r_state    <= S_RUN;
                            addr_valid <= 1'b1;
                            win_first  <= 1'b1;
                            win_last   <= 1'b0;
                            conv_last  <= (cfg_width == DIM_W'(3)) && (cfg_height == DIM_W'(3));
                        end else begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        addr_valid <= 1'b0;
                        win_first  <= 1'b0;
                        win_last   <= 1'b0;
                        conv_last  <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b0;
                    end else if (w_xfer) begin
                        if (w_end) begin
                            r_state    <= S_DONE;
                            addr_valid <= 1'b0;
                            win_first  <= 1'b0;
                            win_last   <= 1'b0;
                            conv_last  <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            r_row       <= w_row;
                            r_col       <= w_col;
                            r_k         <= w_k;
                            r_ky        <= w_ky;
                            r_kx        <= w_kx;
                            r_rowstart  <= w_rowstart;
                            r_win_base  <= w_win_base;
                            r_chan_base <= w_chan_base;
                            r_line_base <= w_line_base;
                            addr        <= w_addr;
                            win_first   <= w_first;
                            win_last    <= w_wlast;
                            conv_last   <= w_clast;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    addr_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_addr_seq.sv
// Self-checking bench for conv_addr_seq: directed scenarios plus randomized configurations
// and backpressure, compared against a nested-loop address model.
module tb_conv_addr_seq;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_width;
    logic [7:0]  cfg_height;
    logic [7:0]  cfg_chans;
    logic        addr_ready;
    logic        addr_valid;
    logic [15:0] addr;
    logic        win_first;
    logic        win_last;
    logic        conv_last;
    logic        busy;
    logic        done;
    logic        err;

    int n_assert = 0;
    int n_fail   = 0;

    conv_addr_seq #(.ADDR_W(16), .DIM_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_chans  (cfg_chans),
        .addr_ready (addr_ready),
        .addr_valid (addr_valid),
        .addr       (addr),
        .win_first  (win_first),
        .win_last   (win_last),
        .conv_last  (conv_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a sequence and follow it to completion (or to an abort on transfer abort_at).
    task automatic run_seq(input int w, input int h, input int c, input int rdy_pct,
                           input int abort_at, input string name);
        int          exp_a[$];
        logic [2:0]  exp_f[$];
        int          total;
        int          stop;
        int          idx;
        int          cyc;
        bit          prev_stall;
        logic [15:0] prev_addr;
        for (int r = 0; r <= h - 3; r++)
            for (int cc = 0; cc <= w - 3; cc++)
                for (int k = 0; k < c; k++)
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++) begin
                            exp_a.push_back((k*w*h + (r+ky)*w + cc + kx) & 32'hFFFF);
                            exp_f.push_back({(k == 0 && ky == 0 && kx == 0),
                                             (k == c-1 && ky == 2 && kx == 2),
                                             (r == h-3 && cc == w-3)});
                        end
        total = exp_a.size();
        stop  = (abort_at > 0) ? abort_at : total;
        @(negedge clk);
        cfg_width  = 8'(w);
        cfg_height = 8'(h);
        cfg_chans  = 8'(c);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cfg_width  = 8'd1;
        cfg_height = 8'd1;
        cfg_chans  = 8'd0;
        chk({name, "_busy_start"}, busy, 1);
        chk({name, "_err_clear"}, err, 0);
        idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        while (idx < stop && cyc < 20000) begin
            if (!addr_valid) begin
                chk({name, "_valid_drop"}, addr_valid, 1);
                break;
            end
            if (prev_stall) chk({name, "_stall_stable"}, addr, prev_addr);
            addr_ready = ($urandom_range(99) < rdy_pct);
            if (addr_ready) begin
                chk({name, "_addr"}, addr, exp_a[idx]);
                chk({name, "_flags"}, {win_first, win_last, conv_last}, exp_f[idx]);
                idx++;
                if (idx == abort_at) abort = 1'b1;
            end
            prev_stall = !addr_ready;
            prev_addr  = addr;
            @(negedge clk);
            abort      = 1'b0;
            addr_ready = 1'b0;
            cyc++;
        end
        chk({name, "_count"}, idx, stop);
        if (abort_at > 0) begin
            chk({name, "_abort_state"}, {addr_valid, done, busy}, 3'b000);
            @(negedge clk);
            chk({name, "_abort_nodone"}, {addr_valid, done, busy}, 3'b000);
        end else begin
            chk({name, "_done_pulse"}, {addr_valid, done, busy}, 3'b011);
            @(negedge clk);
            chk({name, "_idle"}, {addr_valid, done, busy}, 3'b000);
        end
    endtask

    initial begin
        int xfers;
        int cyc;
        bit got_done;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; addr_ready = 1'b0;
        cfg_width = 8'd0; cfg_height = 8'd0; cfg_chans = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_flags", {addr_valid, win_first, win_last, conv_last, busy, done, err}, 7'd0);
        chk("reset_addr", addr, 0);
        rstn = 1'b1;

        run_seq(4, 4, 1, 100, 0, "w4h4c1");
        run_seq(3, 3, 2, 100, 0, "w3h3c2");
        run_seq(5, 4, 3, 100, 0, "w5h4c3_full");
        run_seq(5, 4, 3, 55, 0, "w5h4c3_bp");

        // Rejected configuration
        @(negedge clk);
        cfg_width = 8'd2; cfg_height = 8'd8; cfg_chans = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_cfg_state", {addr_valid, busy, done, err}, 4'b0111);
        @(negedge clk);
        chk("bad_cfg_after", {addr_valid, busy, done, err}, 4'b0001);
        @(negedge clk);
        chk("bad_cfg_err_hold", err, 1);
        run_seq(4, 4, 1, 100, 0, "after_err");

        run_seq(4, 4, 1, 80, 10, "abort10");
        run_seq(4, 4, 1, 100, 0, "restart");

        // Abort beats start in idle; abort on the final transfer suppresses done
        @(negedge clk);
        cfg_width = 8'd4; cfg_height = 8'd4; cfg_chans = 8'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort_start_idle", {addr_valid, busy, done}, 3'b000);
        run_seq(3, 3, 1, 100, 9, "abort_last");

        // Randomized configurations with backpressure
        for (int i = 0; i < 4; i++)
            run_seq($urandom_range(3, 7), $urandom_range(3, 6), $urandom_range(1, 3),
                    $urandom_range(40, 100), 0, "rand");

        // Reset mid-run with start held high
        @(negedge clk);
        cfg_width = 8'd4; cfg_height = 8'd4; cfg_chans = 8'd1; start = 1'b1; addr_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_reset_flags", {addr_valid, win_first, win_last, conv_last, busy, done, err}, 7'd0);
            chk("mid_reset_addr", addr, 0);
        end
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_start", {addr_valid, busy, win_first}, 3'b111);
        chk("post_reset_addr", addr, 0);
        xfers = 0; cyc = 0; got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            if (addr_valid && addr_ready) xfers++;
            @(negedge clk);
            if (done) got_done = 1'b1;
            cyc++;
        end
        start = 1'b0; addr_ready = 1'b0;
        chk("post_reset_done", got_done, 1);
        chk("post_reset_xfers", xfers, 36);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
